// File: rtl/wasm_cmp_pipe.sv
// Pipelined WebAssembly i32/i64 comparison unit with tag passthrough and backpressure.
// Define WASM_CMP_EQZ_EN to add the unary i32.eqz (0x45) and i64.eqz (0x50) ops.
module wasm_cmp_pipe #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_op,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      result,
    output logic [3:0]       trap,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [3:0] TRAP_ILLEGAL = 4'h3;

    logic       legal;
    logic       wide;
    logic       unary;
    logic [3:0] sel;
    logic [63:0] x;
    logic [63:0] y;
    logic eq;
    logic lt_s;
    logic lt_u;
    logic gt_s;
    logic gt_u;
    logic hit;
    logic cmp_res;
    logic [3:0] cmp_trap;
    logic stall;
    logic accept;

    logic [LATENCY-1:0]            st_valid;
    logic [LATENCY-1:0]            st_res;
    logic [LATENCY-1:0][3:0]       st_trap;
    logic [LATENCY-1:0][TAG_W-1:0] st_tag;

    // sel is the position within the eq..ge_u group, shared by both widths
    always_comb begin
        legal = 1'b0;
        wide  = 1'b0;
        unary = 1'b0;
        sel   = 4'd0;
        unique case (1'b1)
            (in_op >= 8'h46 && in_op <= 8'h4F): begin
                legal = 1'b1;
                sel   = in_op[3:0] - 4'h6;
            end
            (in_op >= 8'h51 && in_op <= 8'h5A): begin
                legal = 1'b1;
                wide  = 1'b1;
                sel   = in_op[3:0] - 4'h1;
            end
`ifdef WASM_CMP_EQZ_EN
            (in_op == 8'h45): begin
                legal = 1'b1;
                unary = 1'b1;
            end
            (in_op == 8'h50): begin
                legal = 1'b1;
                unary = 1'b1;
                wide  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Sign-extending i32 operands keeps both signed and unsigned ordering intact
    assign x = wide ? in_a : {{32{in_a[31]}}, in_a[31:0]};
    assign y = wide ? in_b : {{32{in_b[31]}}, in_b[31:0]};

    assign eq   = (x == y);
    assign lt_s = ($signed(x) < $signed(y));
    assign lt_u = (x < y);
    assign gt_s = ($signed(y) < $signed(x));
    assign gt_u = (y < x);

    always_comb begin
        hit = 1'b0;
        case (sel)
            4'd0:    hit = eq;
            4'd1:    hit = ~eq;
            4'd2:    hit = lt_s;
            4'd3:    hit = lt_u;
            4'd4:    hit = gt_s;
            4'd5:    hit = gt_u;
            4'd6:    hit = ~gt_s;
            4'd7:    hit = ~gt_u;
            4'd8:    hit = ~lt_s;
            4'd9:    hit = ~lt_u;
            default: hit = 1'b0;
        endcase
        if (unary) begin
            hit = (y == 64'd0);
        end
    end

    assign cmp_res  = legal & hit;
    assign cmp_trap = legal ? 4'h0 : TRAP_ILLEGAL;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid <= '0;
            st_res   <= '0;
            st_trap  <= '0;
            st_tag   <= '0;
        end else if (!stall) begin
            st_valid[0] <= accept;
            st_res[0]   <= accept & cmp_res;
            st_trap[0]  <= accept ? cmp_trap : 4'h0;
            st_tag[0]   <= accept ? in_tag : '0;
            for (int i = 1; i < LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_res[i]   <= st_res[i-1];
                st_trap[i]  <= st_trap[i-1];
                st_tag[i]   <= st_tag[i-1];
            end
        end
    end

    assign out_valid = st_valid[LATENCY-1];
    assign result    = {63'd0, st_res[LATENCY-1]};
    assign trap      = st_trap[LATENCY-1];
    assign out_tag   = st_tag[LATENCY-1];

endmodule

// File: doc/wasm_cmp_pipe.md
Name: wasm_cmp_pipe

Overview:
- Pipelined WebAssembly integer comparison unit. Executes the full i32/i64 relational opcode set (eq, ne, lt/gt/le/ge in signed and unsigned forms).
- Generalises the single-op compare path exercised by the cpu i32.ne test: configurable latency, tag passthrough and valid/ready backpressure.
- Sits between the cpu operand-stack pop stage and the stack push/writeback stage. Accepts one op per cycle when not stalled.

Parameters:
- LATENCY, 2, pipeline depth in cycles from accepted input to out_valid. Legal range 1..4.
- TAG_W, 4, width of the opaque tag carried alongside each op (stack slot or sequence id).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  opcode and operands are presented.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  8  WebAssembly opcode byte.
- in_a  in  64  first operand (the deeper stack entry). i32 ops use bits [31:0].
- in_b  in  64  second operand (the top-of-stack entry). i32 ops use bits [31:0].
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result is held on the outputs.
- out_ready  in  1  consumer accepts the result.
- result  out  64  comparison result, zero-extended: 0 or 1.
- trap  out  4  0 = none; 4'h3 = illegal opcode for this unit.
- out_tag  out  TAG_W  tag of the op in the output stage.

Behaviour:
- Pipeline structure:
  - LATENCY register stages, each holding valid, result, trap and tag.
  - The comparison is evaluated combinationally from the inputs and registered into stage 0.
  - Stages 1..LATENCY-1 are pure delay.
  - Outputs come from stage LATENCY-1.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall. This is combinational from out_valid/out_ready only, not from in_valid.
  - Accept = in_valid & in_ready.
- Clocking:
  - When not stalled, all stages advance every cycle. Stage 0 valid <= accept.
  - When stalled, no stage changes. Bubbles are not collapsed.
- Latency and throughput:
  - An op accepted at edge N appears with out_valid=1 after edge N+LATENCY-1 when no stall occurs.
  - Throughput is 1 op/cycle.
  - Ordering is strictly FIFO.
- Opcode map:
  - i32: 0x46 eq, 0x47 ne, 0x48 lt_s, 0x49 lt_u, 0x4A gt_s, 0x4B gt_u, 0x4C le_s, 0x4D le_u, 0x4E ge_s, 0x4F ge_u.
  - i64: 0x51..0x5A in the same order.
  - All comparisons evaluate a OP b. Signed ops use two's complement at the op width (bit 31 or bit 63 is the sign).
  - i32 ops ignore bits [63:32] of both operands.
- Result format:
  - result[63:1] is always 0.
  - For a legal op, trap = 0.
- Illegal opcodes:
  - Any opcode not in the map (and 0x45/0x50 when the optional feature is off) gives result=0, trap=4'h3.
  - The op still flows through the pipeline and returns its tag.
  - The trap is held on the outputs for that op only.
- Reset:
  - Synchronous reset clears all stage valids, results, traps and tags to 0.
  - Output values after reset: out_valid=0, result=0, trap=0, out_tag=0, in_ready=1.
  - Reset asserted mid-operation drops every in-flight op. No result for those ops is ever presented.
- Simultaneous events:
  - If out_ready=1 while out_valid=1, the output is consumed and a new input is accepted in the same cycle.
  - reset has priority over every other input.
- With out_valid=0, out_ready is don't-care.

Optional Feature:
- Macro: WASM_CMP_EQZ_EN.
- Defined: unary 0x45 i32.eqz and 0x50 i64.eqz are supported.
  - The operand is taken from in_b; in_a is ignored.
  - result = 1 iff the operand is zero at the op width.
- Not defined: 0x45 and 0x50 are illegal and give trap=4'h3.

Test Plan:
- LATENCY=2, in_op=0x47, a=1, b=2, out_ready=1 -> out_valid=1 two cycles after accept; result=1, trap=0, out_tag=in_tag.
- i32 masking: 0x46, a=64'h1_00000005, b=64'h5 -> result=1. Same operands with 0x51 -> result=0.
- Signedness: 0x48, a=32'hFFFFFFFF, b=1 -> result=1. 0x49 on the same operands -> result=0. 0x55, a=64'h8000_0000_0000_0000, b=0 -> result=0.
- Back-to-back and backpressure:
  - Stimulus: 4 ops with tags 1..4; hold out_ready=0 for 3 cycles starting when tag 1 appears.
  - Required: in_ready=0 throughout the stall; tag 1 output held stable; all tags emerge in order with no loss or duplication.
- Illegal op: 0x60 -> result=0, trap=4'h3, tag returned. With WASM_CMP_EQZ_EN undefined, 0x45 -> trap=4'h3. With it defined, 0x45 and b=0 -> result=1.
- Reset mid-flight: accept 2 ops, assert reset for 1 cycle -> out_valid=0 and in_ready=1 after reset; neither op's result ever appears.
